ssd_scan_driver: RTL and testbench
==================================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter c_HEX_DEC, default 9, decode mode: 9 decimal, 15 hexadecimal.
REQ-002 SHALL have parameter c_REFRESH_DIV, default 100000, clock cycles each digit is displayed (minimum 2).
REQ-003 SHALL have port i_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports i_Digit_1_val..i_Digit_4_val  input  4 each  digit values, digit 1 most significant.
REQ-006 SHALL have port i_DP  input  4  decimal-point request, bit 3 = digit 1.
REQ-007 SHALL have port i_Blank  input  1  force display dark; scanning continues.
REQ-008 SHALL have port o_Anode  output  4  active-low digit enables, bit 3 = digit 1.
REQ-009 SHALL have port o_Cathode  output  7  active-low segments, order gfedcba.
REQ-010 SHALL have port o_DP  output  1  active-low decimal point.

Function
REQ-011 Prescaler SHALL count 0..c_REFRESH_DIV-1 and wrap; at terminal count, select SHALL advance D1->D2->D3->D4->D1.
REQ-012 Four-entry snapshot SHALL load all four digit inputs and i_DP in any cycle where prescaler==0 and select==D1; it SHALL be held for the whole frame (no tearing).
REQ-013 Outputs SHALL be registered: at each edge, o_Anode/o_Cathode/o_DP take the decode of current select and snapshot (one-cycle lag behind select).
REQ-014 Active digit's o_Anode bit SHALL be 0, others 1.
REQ-015 Segment table (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-016 With c_HEX_DEC==9, values 10-15 SHALL display dash 0111111; with 15, full table.
REQ-017 o_DP SHALL be the inverse of the snapshot DP bit of the active digit.
REQ-018 i_Blank high SHALL force o_Anode=1111 at the next edge; prescaler, select and snapshot unaffected.
REQ-019 A blanked digit SHALL drive its anode 1 for its whole slot; select timing unchanged.

Reset
REQ-020 i_RST_N low at an edge SHALL set prescaler 0, select D1, snapshot all 0, o_Anode 1111, o_Cathode 1111111, o_DP 1.
REQ-021 Reset mid-frame SHALL take priority over all other activity; first cycle after release loads snapshot and shows D1 at the following edge.

Configuration
REQ-022 Macro SSD_LEADING_ZERO_BLANK_EN defined: D1 blanked if snapshot D1==0; D2 if D1,D2==0; D3 if D1..D3==0; D4 never blanked; DP does not inhibit blanking.
REQ-023 Macro undefined: no leading-zero blanking; all four digits always shown unless i_Blank.

Structure
REQ-024 Package ssd_pkg SHALL hold the select-state typedef (D1..D4), the 16-entry segment constant table, dash and all-off constants.
REQ-025 Sub-module ssd_seg_decoder (combinational, 4-bit value + mode -> 7-bit cathode) SHALL implement REQ-015/016.

Verification (c_REFRESH_DIV=4)
REQ-026 Reset, digits 1,2,3,4 -> o_Anode 0111,1011,1101,1110 each 4 cycles repeating; cathode 1111001,0100100,0110000,0011001 accordingly.
REQ-027 c_HEX_DEC=9, D4=4'hA -> dash 0111111 in slot D4; c_HEX_DEC=15 -> 0001000.
REQ-028 Change D1 from 1 to 7 while D3 shown -> slot D1 shows 1111001 until next frame, then 1111000.
REQ-029 Macro defined, digits 0,0,5,0 -> anodes 1111,1111,1101,1110 per slot, D4 cathode 1000000; undefined -> all four anodes asserted in turn.
REQ-030 i_RST_N low during D3 slot -> next edge outputs 1111/1111111/1; after release D1 shown, 4 cycles.
REQ-031 i_Blank high 6 cycles mid-frame -> o_Anode 1111 throughout; afterwards select continues where prescaler dictates.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
// Segment patterns are active-low, ordered gfedcba.
package ssd_pkg;

  typedef enum logic [1:0] {
    D1 = 2'd0,
    D2 = 2'd1,
    D3 = 2'd2,
    D4 = 2'd3
  } sel_e;

  localparam int HEX_MODE = 15;
  localparam int DEC_MODE = 9;

  localparam logic [0:15][6:0] SEG_TABLE = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/ssd_seg_decoder.sv
// Combinational digit-to-segment decoder.
// Decimal mode shows a dash for values above 9.
module ssd_seg_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_TABLE[i_val];
    if (!i_hex && (i_val > 4'd9)) begin
      o_seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame snapshot.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int c_HEX_DEC     = 9,
  parameter int c_REFRESH_DIV = 100000
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  input  logic [3:0] i_DP,
  input  logic       i_Blank,
  output logic [3:0] o_Anode,
  output logic [6:0] o_Cathode,
  output logic       o_DP
);

  localparam int PW = (c_REFRESH_DIV > 2) ? $clog2(c_REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(c_REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  sel_e          sel_q, sel_d;
  logic [3:0]    d1_q, d1_d, d2_q, d2_d;
  logic [3:0]    d3_q, d3_d, d4_q, d4_d;
  logic [3:0]    dps_q, dps_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cath_q, cath_d;
  logic          dp_q, dp_d;

  logic [3:0] cur_val;
  logic       cur_dp;
  logic [3:0] cur_an;
  logic       lz_blank;
  logic [6:0] seg;

  always_comb begin
    presc_d = presc_q + PW'(1);
    sel_d   = sel_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      unique case (sel_q)
        D1: sel_d = D2;
        D2: sel_d = D3;
        D3: sel_d = D4;
        D4: sel_d = D1;
      endcase
    end
  end

  always_comb begin
    d1_d  = d1_q;
    d2_d  = d2_q;
    d3_d  = d3_q;
    d4_d  = d4_q;
    dps_d = dps_q;
    if ((presc_q == '0) && (sel_q == D1)) begin
      d1_d  = i_Digit_1_val;
      d2_d  = i_Digit_2_val;
      d3_d  = i_Digit_3_val;
      d4_d  = i_Digit_4_val;
      dps_d = i_DP;
    end
  end

  // Decode from the snapshot as it stands after this edge's load so the
  // first D1 slot of a frame already shows the freshly captured value.
  always_comb begin
    cur_val = d1_d;
    cur_dp  = dps_d[3];
    cur_an  = 4'b0111;
    unique case (sel_q)
      D1: begin
        cur_val = d1_d;
        cur_dp  = dps_d[3];
        cur_an  = 4'b0111;
      end
      D2: begin
        cur_val = d2_d;
        cur_dp  = dps_d[2];
        cur_an  = 4'b1011;
      end
      D3: begin
        cur_val = d3_d;
        cur_dp  = dps_d[1];
        cur_an  = 4'b1101;
      end
      D4: begin
        cur_val = d4_d;
        cur_dp  = dps_d[0];
        cur_an  = 4'b1110;
      end
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    unique case (sel_q)
      D1: lz_blank = (d1_d == 4'd0);
      D2: lz_blank = (d1_d == 4'd0) && (d2_d == 4'd0);
      D3: lz_blank = (d1_d == 4'd0) && (d2_d == 4'd0)
                  && (d3_d == 4'd0);
      D4: lz_blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  ssd_seg_decoder u_dec (
    .i_val (cur_val),
    .i_hex (c_HEX_DEC == HEX_MODE),
    .o_seg (seg)
  );

  always_comb begin
    anode_d = cur_an;
    if (i_Blank || lz_blank) begin
      anode_d = ANODE_OFF;
    end
    cath_d = seg;
    dp_d   = ~cur_dp;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      presc_q <= '0;
      sel_q   <= D1;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
      dps_q   <= '0;
      anode_q <= ANODE_OFF;
      cath_q  <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
      dps_q   <= dps_d;
      anode_q <= anode_d;
      cath_q  <= cath_d;
      dp_q    <= dp_d;
    end
  end

  assign o_Anode   = anode_q;
  assign o_Cathode = cath_q;
  assign o_DP      = dp_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a 4-cycle refresh divider.
// Runs decimal and hex instances side by side.
module tb_ssd_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d1, d2, d3, d4, dp;
  logic       blank;
  logic [3:0] an9, an15;
  logic [6:0] ca9, ca15;
  logic       dp9, dp15;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_an [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] exp_ca [4] = '{7'b1111001, 7'b0100100,
                             7'b0110000, 7'b0011001};

  always #5 clk = ~clk;

  ssd_scan_driver #(.c_HEX_DEC(9), .c_REFRESH_DIV(4)) dut9 (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_Digit_1_val(d1), .i_Digit_2_val(d2),
    .i_Digit_3_val(d3), .i_Digit_4_val(d4),
    .i_DP(dp), .i_Blank(blank),
    .o_Anode(an9), .o_Cathode(ca9), .o_DP(dp9)
  );

  ssd_scan_driver #(.c_HEX_DEC(15), .c_REFRESH_DIV(4)) dut15 (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_Digit_1_val(d1), .i_Digit_2_val(d2),
    .i_Digit_3_val(d3), .i_Digit_4_val(d4),
    .i_DP(dp), .i_Blank(blank),
    .o_Anode(an15), .o_Cathode(ca15), .o_DP(dp15)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] a, b, c, e, p);
    d1 = a; d2 = b; d3 = c; d4 = e; dp = p;
    blank = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    total++;
    if (an9 !== 4'b1111) begin
      bad++;
      $display("FAIL reset_anode got=%b want=1111", an9);
    end
    total++;
    if (ca9 !== 7'b1111111) begin
      bad++;
      $display("FAIL reset_cathode got=%b want=1111111", ca9);
    end
    total++;
    if (dp9 !== 1'b1) begin
      bad++;
      $display("FAIL reset_dp got=%b want=1", dp9);
    end
  endtask

  task automatic test_scan();
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    for (int k = 0; k < 32; k++) begin
      step();
      total++;
      if (an9 !== exp_an[(k/4)%4]) begin
        bad++;
        $display("FAIL scan_anode k=%0d got=%b want=%b",
                 k, an9, exp_an[(k/4)%4]);
      end
      total++;
      if (ca9 !== exp_ca[(k/4)%4]) begin
        bad++;
        $display("FAIL scan_cathode k=%0d got=%b want=%b",
                 k, ca9, exp_ca[(k/4)%4]);
      end
    end
  endtask

  task automatic test_hex();
    do_reset(4'd1, 4'd2, 4'd3, 4'hA, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      step();
      if (k >= 12) begin
        total++;
        if (ca9 !== 7'b0111111) begin
          bad++;
          $display("FAIL dec_dash k=%0d got=%b want=0111111",
                   k, ca9);
        end
        total++;
        if (ca15 !== 7'b0001000) begin
          bad++;
          $display("FAIL hex_a k=%0d got=%b want=0001000",
                   k, ca15);
        end
      end
    end
  endtask

  task automatic test_no_tear();
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    step();
    d1 = 4'd7;
    for (int k = 1; k < 4; k++) begin
      step();
      total++;
      if (ca9 !== 7'b1111001) begin
        bad++;
        $display("FAIL tear_d1_slot k=%0d got=%b want=1111001",
                 k, ca9);
      end
    end
    for (int k = 4; k < 9; k++) step();
    d1 = 4'd7;
    for (int k = 9; k < 16; k++) step();
    for (int k = 16; k < 20; k++) begin
      step();
      total++;
      if (ca9 !== 7'b1111000 || an9 !== 4'b0111) begin
        bad++;
        $display("FAIL tear_next k=%0d got=%b/%b want=0111/1111000",
                 k, an9, ca9);
      end
    end
  endtask

  task automatic test_lzb();
    logic [3:0] want [4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
    want = '{4'b1111, 4'b1111, 4'b1101, 4'b1110};
`else
    want = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
`endif
    do_reset(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      step();
      total++;
      if (an9 !== want[k/4]) begin
        bad++;
        $display("FAIL lzb_anode k=%0d got=%b want=%b",
                 k, an9, want[k/4]);
      end
    end
    total++;
    if (ca9 !== 7'b1000000) begin
      bad++;
      $display("FAIL lzb_d4_cathode got=%b want=1000000", ca9);
    end
  endtask

  task automatic test_dp();
    logic want;
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b1010);
    for (int k = 0; k < 16; k++) begin
      step();
      want = ((k/4) % 2 == 0) ? 1'b0 : 1'b1;
      total++;
      if (dp9 !== want) begin
        bad++;
        $display("FAIL dp k=%0d got=%b want=%b", k, dp9, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    for (int k = 0; k < 9; k++) step();
    total++;
    if (an9 !== 4'b1101) begin
      bad++;
      $display("FAIL mid_pre got=%b want=1101", an9);
    end
    dp = 4'b1111;
    rst_n = 1'b0;
    step();
    total++;
    if (an9 !== 4'b1111 || ca9 !== 7'b1111111 || dp9 !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%b want=1111/1111111/1",
               an9, ca9, dp9);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (an9 !== ((k < 4) ? 4'b0111 : 4'b1011)) begin
        bad++;
        $display("FAIL mid_release k=%0d got=%b", k, an9);
      end
    end
  endtask

  task automatic test_blank();
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    step();
    step();
    blank = 1'b1;
    for (int k = 2; k < 8; k++) begin
      step();
      total++;
      if (an9 !== 4'b1111) begin
        bad++;
        $display("FAIL blank k=%0d got=%b want=1111", k, an9);
      end
    end
    blank = 1'b0;
    step();
    total++;
    if (an9 !== 4'b1101 || ca9 !== 7'b0110000) begin
      bad++;
      $display("FAIL blank_after got=%b/%b want=1101/0110000",
               an9, ca9);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    blank = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0; dp = '0;
    test_reset();
    test_scan();
    test_hex();
    test_no_tear();
    test_lzb();
    test_dp();
    test_reset_mid();
    test_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
